// File: rtl/gpio_regbank_pkg.sv
// Shared definitions for the GPIO register bank: register indices, bus width
// and legal parameter limits.
package gpio_regbank_pkg;

  localparam int BUS_W           = 32;
  localparam int MAX_GPIO_W      = 32;
  localparam int MIN_SYNC_STAGES = 2;

  localparam logic [2:0] ADDR_OUT      = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IN       = 3'd2;
  localparam logic [2:0] ADDR_SET      = 3'd3;
  localparam logic [2:0] ADDR_CLR      = 3'd4;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd5;
  localparam logic [2:0] ADDR_IRQ_MODE = 3'd6;
  localparam logic [2:0] ADDR_IRQ_STAT = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop chain that brings asynchronous pad inputs into the clk
// domain. The last stage is the synchronised value.
module gpio_sync
  import gpio_regbank_pkg::*;
#(
  parameter int GPIO_W      = 11,
  parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GPIO_W-1:0] async_i,
  output logic [GPIO_W-1:0] sync_o
);

  logic [GPIO_W-1:0] stage_q [SYNC_STAGES];

  // Shift the pad sample one stage deeper every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_regbank.sv
// Memory-mapped GPIO peripheral: OUT/DIR registers with atomic set/clear,
// synchronised inputs, per-bit rising/falling edge interrupts with W1C status.
module gpio_regbank
  import gpio_regbank_pkg::*;
#(
  parameter int                GPIO_W      = 11,
  parameter int                SYNC_STAGES = 2,
  parameter logic [GPIO_W-1:0] OUT_RESET   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_en,
  input  logic              bus_we,
  input  logic [2:0]        bus_addr,
  input  logic [BUS_W-1:0]  bus_wdata,
  output logic [BUS_W-1:0]  bus_rdata,
  output logic              bus_rvalid,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  // Counter starts one above the synchroniser depth so that a pad already
  // high at reset release has fully propagated into prev before edges count.
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] dir_q, dir_d;
  logic [GPIO_W-1:0] en_q, en_d;
  logic [GPIO_W-1:0] mode_q, mode_d;
  logic [GPIO_W-1:0] stat_q, stat_d;
  logic [GPIO_W-1:0] prev_q;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [BUS_W-1:0]  rdata_q, rdata_d;
  logic              rvalid_q;
  logic              irq_q;

  logic [GPIO_W-1:0] in_sync;
  logic [GPIO_W-1:0] wd;
  logic [GPIO_W-1:0] w1c;
  logic [GPIO_W-1:0] edge_hit;
  logic [BUS_W-1:0]  rd_mux;
  logic              wr, rd;
  logic              unused_wdata;

  gpio_sync #(
    .GPIO_W      (GPIO_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (gpio_in),
    .sync_o  (in_sync)
  );

  assign wr           = bus_en & bus_we;
  assign rd           = bus_en & ~bus_we;
  assign wd           = bus_wdata[GPIO_W-1:0];
  assign unused_wdata = ^bus_wdata;

  // Selected edge per bit, gated by enable and by the post-reset warm-up.
  always_comb begin
    edge_hit = '0;
    if (warm_q == '0) begin
      edge_hit = (((in_sync & ~prev_q) & ~mode_q) |
                  ((~in_sync & prev_q) & mode_q)) & en_q;
    end
    warm_d = (warm_q != '0) ? warm_q - 1'b1 : warm_q;
  end

  // Register writes, set/clear and status update (a new edge beats W1C).
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    en_d   = en_q;
    mode_d = mode_q;
    w1c    = '0;
    if (wr) begin
      case (bus_addr)
        ADDR_OUT:      out_d  = wd;
        ADDR_DIR:      dir_d  = wd;
        ADDR_SET:      out_d  = out_q | wd;
        ADDR_CLR:      out_d  = out_q & ~wd;
        ADDR_IRQ_EN:   en_d   = wd;
        ADDR_IRQ_MODE: mode_d = wd;
        ADDR_IRQ_STAT: w1c    = wd;
        default:       ;
      endcase
    end
    stat_d = (stat_q & ~w1c) | edge_hit;
  end

  // Read mux; SET/CLR read as zero and upper bits are always zero.
  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      ADDR_OUT:      rd_mux[GPIO_W-1:0] = out_q;
      ADDR_DIR:      rd_mux[GPIO_W-1:0] = dir_q;
      ADDR_IN:       rd_mux[GPIO_W-1:0] = in_sync;
      ADDR_IRQ_EN:   rd_mux[GPIO_W-1:0] = en_q;
      ADDR_IRQ_MODE: rd_mux[GPIO_W-1:0] = mode_q;
      ADDR_IRQ_STAT: rd_mux[GPIO_W-1:0] = stat_q;
      default:       rd_mux = '0;
    endcase
    rdata_d = rd ? rd_mux : rdata_q;
  end

  // State registers; reset also drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= OUT_RESET;
      dir_q    <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      stat_q   <= '0;
      prev_q   <= '0;
      warm_q   <= WARM_INIT;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      stat_q   <= stat_d;
      prev_q   <= in_sync;
      warm_q   <= warm_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rd;
      irq_q    <= |(stat_q & en_q);
    end
  end

  assign gpio_out   = out_q;
  assign gpio_oe    = dir_q;
  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_regbank.sv
// Testbench for gpio_regbank: register-access vector tables, directed
// interrupt/warm-up/reset sequences, and randomized traffic against a
// cycle-level reference model.
module tb_gpio_regbank;

  localparam int GW = 11;
  localparam int SS = 2;

  localparam logic [2:0] A_OUT = 3'd0, A_DIR = 3'd1, A_IN = 3'd2, A_SET = 3'd3,
                         A_CLR = 3'd4, A_EN = 3'd5, A_MODE = 3'd6, A_STAT = 3'd7;

  logic          clk;
  logic          reset;
  logic          bus_en;
  logic          bus_we;
  logic [2:0]    bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          bus_rvalid;
  logic [GW-1:0] gpio_in;
  logic [GW-1:0] gpio_out;
  logic [GW-1:0] gpio_oe;
  logic          irq;

  gpio_regbank #(
    .GPIO_W      (GW),
    .SYNC_STAGES (SS),
    .OUT_RESET   ('0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_en     (bus_en),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oe    (gpio_oe),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  vec_t        tbl[$];
  logic [31:0] rdv;
  logic        rvv;

  // reference model state
  logic [GW-1:0] m_out, m_dir, m_en, m_mode, m_stat, m_ev, m_w1c;
  logic [GW-1:0] hist[$];
  logic [GW-1:0] in_c, prev_c, pins, d;
  logic [31:0]   m_rdata, exp_rd;
  logic          exp_irq;
  int            op;
  logic [2:0]    raddr;
  logic [31:0]   rwdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = v;
    tick();
    bus_en = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v, output logic vld);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    tick();
    v = bus_rdata; vld = bus_rvalid;
    bus_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] v;
    logic        vld;
    bus_read(a, v, vld);
    check({name, "_rvalid"}, 32'(vld), 32'd1);
    check(name, v, exp);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we) bus_write(tbl[i].addr, tbl[i].data);
      else read_check($sformatf("vec%0d_a%0d", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
    end
    tbl.delete();
  endtask

  initial begin
    reset = 1'b1; bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    gpio_in = '0;
    tick(); tick();
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rvalid", 32'(bus_rvalid), 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    reset = 1'b0;

    // reset values of all eight indices
    for (int a = 0; a < 8; a++) tbl.push_back('{1'b0, 3'(a), 32'h0, 32'h0});
    run_table();

    // register writes, width rules, read-after-write
    tbl.push_back('{1'b1, A_OUT,  32'h0000_0007, 32'h0});
    tbl.push_back('{1'b1, A_DIR,  32'h0000_07FF, 32'h0});
    tbl.push_back('{1'b1, A_SET,  32'hFFFF_F400, 32'h0});
    tbl.push_back('{1'b1, A_CLR,  32'h0000_0001, 32'h0});
    tbl.push_back('{1'b0, A_OUT,  32'h0,         32'h0000_0406});
    tbl.push_back('{1'b0, A_DIR,  32'h0,         32'h0000_07FF});
    tbl.push_back('{1'b0, A_SET,  32'h0,         32'h0});
    tbl.push_back('{1'b0, A_CLR,  32'h0,         32'h0});
    tbl.push_back('{1'b1, A_IN,   32'h0000_07FF, 32'h0});
    tbl.push_back('{1'b0, A_IN,   32'h0,         32'h0});
    tbl.push_back('{1'b1, A_MODE, 32'hFFFF_F800, 32'h0});
    tbl.push_back('{1'b0, A_MODE, 32'h0,         32'h0});
    tbl.push_back('{1'b1, A_EN,   32'h0000_0155, 32'h0});
    tbl.push_back('{1'b0, A_EN,   32'h0,         32'h0000_0155});
    tbl.push_back('{1'b1, A_EN,   32'h0,         32'h0});
    tbl.push_back('{1'b0, A_STAT, 32'h0,         32'h0});
    run_table();
    check("gpio_out_406", 32'(gpio_out), 32'h406);
    check("gpio_oe_7ff", 32'(gpio_oe), 32'h7FF);

    // input latency, back-to-back reads, no irq while disabled
    gpio_in = 11'h001;
    read_check("in_lat0", A_IN, 32'h0);
    read_check("in_lat1", A_IN, 32'h0);
    read_check("in_lat2", A_IN, 32'h1);
    check("irq_disabled", 32'(irq), 32'h0);
    read_check("stat_disabled", A_STAT, 32'h0);
    gpio_in = '0;
    repeat (4) tick();

    // rising edge on bit0, irq timing, W1C
    bus_write(A_EN, 32'h1);
    bus_write(A_MODE, 32'h0);
    gpio_in = 11'h001; tick(); gpio_in = '0; tick(); tick();
    check("irq_before", 32'(irq), 32'h0);
    tick();
    check("irq_rise", 32'(irq), 32'h1);
    read_check("stat_rise", A_STAT, 32'h1);
    bus_write(A_STAT, 32'h1);
    check("irq_lag_w1c", 32'(irq), 32'h1);
    tick();
    check("irq_cleared", 32'(irq), 32'h0);
    read_check("stat_cleared", A_STAT, 32'h0);

    // falling-edge mode on bit1
    bus_write(A_MODE, 32'h2);
    bus_write(A_EN, 32'h2);
    gpio_in = 11'h002;
    repeat (5) tick();
    read_check("stat_no_rise", A_STAT, 32'h0);
    check("irq_no_rise", 32'(irq), 32'h0);
    gpio_in = '0;
    repeat (5) tick();
    read_check("stat_fall", A_STAT, 32'h2);
    check("irq_fall", 32'(irq), 32'h1);
    bus_write(A_STAT, 32'h2);
    tick();
    check("irq_fall_clr", 32'(irq), 32'h0);
    read_check("stat_fall_clr", A_STAT, 32'h0);

    // edge and W1C on the same cycle: set wins
    bus_write(A_MODE, 32'h0);
    bus_write(A_EN, 32'h1);
    gpio_in = 11'h001; tick(); gpio_in = '0;
    repeat (5) tick();
    check("irq_pre_same", 32'(irq), 32'h1);
    gpio_in = 11'h001; tick(); gpio_in = '0; tick();
    bus_write(A_STAT, 32'h1);
    check("irq_same0", 32'(irq), 32'h1);
    tick();
    check("irq_same1", 32'(irq), 32'h1);
    read_check("stat_same", A_STAT, 32'h1);
    bus_write(A_STAT, 32'h1);
    tick(); tick();
    check("irq_same_clr", 32'(irq), 32'h0);

    // reset during a read, then warm-up suppression with pads high
    bus_write(A_OUT, 32'h5A5);
    bus_write(A_DIR, 32'h0F0);
    gpio_in = 11'h7FF;
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = A_OUT; reset = 1'b1;
    tick();
    bus_en = 1'b0;
    check("rstrd_rvalid", 32'(bus_rvalid), 32'h0);
    check("rstrd_rdata", bus_rdata, 32'h0);
    check("rstrd_out", 32'(gpio_out), 32'h0);
    check("rstrd_oe", 32'(gpio_oe), 32'h0);
    check("rstrd_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    bus_write(A_EN, 32'h7FF);
    repeat (6) tick();
    read_check("warm_stat", A_STAT, 32'h0);
    check("warm_irq", 32'(irq), 32'h0);
    read_check("warm_in", A_IN, 32'h7FF);
    read_check("warm_out", A_OUT, 32'h0);
    read_check("warm_dir", A_DIR, 32'h0);
    read_check("warm_mode", A_MODE, 32'h0);

    // randomized traffic against the reference model
    gpio_in = '0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    repeat (8) tick();
    m_out = '0; m_dir = '0; m_en = '0; m_mode = '0; m_stat = '0; m_rdata = '0;
    pins = '0;
    hist.delete();
    for (int k = 0; k <= SS; k++) hist.push_back('0);

    for (int i = 0; i < 300; i++) begin
      op     = $urandom_range(0, 3);
      raddr  = 3'($urandom_range(0, 7));
      rwdata = $urandom;
      if ($urandom_range(0, 2) == 0) pins = GW'($urandom);

      // values visible before the edge
      in_c    = hist[SS-1];
      prev_c  = hist[SS];
      exp_irq = |(m_stat & m_en);
      m_ev    = '0;
      for (int b = 0; b < GW; b++)
        if (m_en[b] && (m_mode[b] ? (prev_c[b] && !in_c[b]) : (in_c[b] && !prev_c[b])))
          m_ev[b] = 1'b1;
      case (raddr)
        A_OUT:   exp_rd = 32'(m_out);
        A_DIR:   exp_rd = 32'(m_dir);
        A_IN:    exp_rd = 32'(in_c);
        A_EN:    exp_rd = 32'(m_en);
        A_MODE:  exp_rd = 32'(m_mode);
        A_STAT:  exp_rd = 32'(m_stat);
        default: exp_rd = 32'h0;
      endcase

      m_w1c = '0;
      d     = rwdata[GW-1:0];
      if (op >= 2) begin
        case (raddr)
          A_OUT:   m_out  = d;
          A_DIR:   m_dir  = d;
          A_SET:   m_out  = m_out | d;
          A_CLR:   m_out  = m_out & ~d;
          A_EN:    m_en   = d;
          A_MODE:  m_mode = d;
          A_STAT:  m_w1c  = d;
          default: ;
        endcase
      end
      m_stat = (m_stat & ~m_w1c) | m_ev;
      if (op == 1) m_rdata = exp_rd;

      gpio_in = pins;
      bus_en = (op != 0); bus_we = (op >= 2); bus_addr = raddr; bus_wdata = rwdata;
      tick();
      bus_en = 1'b0; bus_we = 1'b0;
      hist.push_front(pins);
      void'(hist.pop_back());

      check($sformatf("rnd%0d_out", i), 32'(gpio_out), 32'(m_out));
      check($sformatf("rnd%0d_oe", i), 32'(gpio_oe), 32'(m_dir));
      check($sformatf("rnd%0d_irq", i), 32'(irq), 32'(exp_irq));
      check($sformatf("rnd%0d_rvalid", i), 32'(bus_rvalid), 32'(op == 1));
      check($sformatf("rnd%0d_rdata", i), bus_rdata, m_rdata);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpio_regbank.md
Name: gpio_regbank

Overview:
- Parametrised memory-mapped GPIO peripheral for the user project. It generalises the fixed 11-in/11-out GPIO path driven by the vscpu cores.
- Per-bit direction control, atomic set/clear, multi-stage input synchronisation, and per-bit edge interrupts with write-1-to-clear status.
- Sits on the core data bus beside main memory.
- gpio_in, gpio_out and gpio_oe go to mprj_io pads; irq goes to the core's interrupt input.

Parameters:
- GPIO_W, 11, number of GPIO channels (1..32).
- SYNC_STAGES, 2, flip-flop stages on gpio_in (2..4).
- OUT_RESET, 0, reset value of the OUT register (GPIO_W bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bus_en  in  1  bus access strobe, one cycle per access.
- bus_we  in  1  1 = write, 0 = read; qualified by bus_en.
- bus_addr  in  3  register index.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, valid when bus_rvalid=1.
- bus_rvalid  out  1  read data valid pulse.
- gpio_in  in  GPIO_W  asynchronous pad inputs.
- gpio_out  out  GPIO_W  pad output values.
- gpio_oe  out  GPIO_W  pad output enables, 1 = drive.
- irq  out  1  level interrupt.

Behaviour:
- Clocking and reset: single clock clk. Reset is synchronous and active-high on port reset; every register below clears on it.
- Reset values:
  - OUT = OUT_RESET.
  - DIR = 0 (all inputs).
  - IRQ_EN = 0, IRQ_MODE = 0, IRQ_STAT = 0.
  - Synchroniser stages and prev-sample register = 0.
  - bus_rdata = 0, bus_rvalid = 0, irq = 0.
  - Warm-up counter = SYNC_STAGES+1.
- Register map (bus_addr):
  - 0 OUT, rw.
  - 1 DIR, rw.
  - 2 IN, ro, synchronised value.
  - 3 SET, wo: OUT |= wdata.
  - 4 CLR, wo: OUT &= ~wdata.
  - 5 IRQ_EN, rw.
  - 6 IRQ_MODE, rw; per bit 0 = rising, 1 = falling.
  - 7 IRQ_STAT, read / write-1-to-clear.
- Width rules:
  - Only wdata[GPIO_W-1:0] is used.
  - Read bits [31:GPIO_W] are 0.
  - Reads of SET and CLR return 0.
  - Writes to IN are ignored.
- Write timing: a write takes effect on the clk edge where bus_en & bus_we. The new OUT/DIR value is visible on gpio_out/gpio_oe on the following cycle.
- Read timing: a read (bus_en & ~bus_we) is registered. bus_rvalid=1 and bus_rdata are valid exactly one cycle later. Otherwise bus_rvalid=0 and bus_rdata holds its last value.
- Back-to-back: reads on consecutive cycles are fully pipelined, one result per cycle.
- Read-after-write to the same register, one cycle apart, returns the new value.
- Outputs: gpio_out = OUT and gpio_oe = DIR, both registered. Bits with DIR=0 still drive OUT onto gpio_out, but oe is low.
- Input path:
  - gpio_in passes through SYNC_STAGES flops; the last stage is IN.
  - A prev register holds IN delayed by one cycle.
  - Total input-to-IN latency is SYNC_STAGES cycles.
- Edge detect: rise = IN & ~prev; fall = ~IN & prev. Per bit, the selected edge is rise when IRQ_MODE=0 and fall when IRQ_MODE=1.
- Edges are detected on all bits regardless of DIR, so loopback is testable.
- Warm-up:
  - After reset the counter decrements to 0, one step per cycle.
  - Edge detection is suppressed while the counter is non-zero, so a pad already high at reset release does not flag a rising edge.
- Status update, per bit, each cycle: STAT_next = (STAT & ~w1c) | (sel_edge & IRQ_EN).
  - w1c is wdata on a write to index 7.
  - An edge and a W1C on the same bit in the same cycle: set wins.
  - Disabled bits never set. Clearing IRQ_EN does not clear pending STAT.
- irq is registered: irq = |(IRQ_STAT & IRQ_EN). It follows the status change by one cycle.
- Reset asserted mid-access: the pending read is dropped (bus_rvalid=0 next cycle) and all state returns to reset values.
- bus_addr out of range cannot occur (3 bits, all decoded).

Decomposition:
- Shared package gpio_regbank_pkg holds:
  - localparams for the register indices: ADDR_OUT=0, ADDR_DIR=1, ADDR_IN=2, ADDR_SET=3, ADDR_CLR=4, ADDR_IRQ_EN=5, ADDR_IRQ_MODE=6, ADDR_IRQ_STAT=7;
  - bus data width 32;
  - limits MAX_GPIO_W=32 and MIN_SYNC_STAGES=2.
- One sub-module, gpio_sync: a parametrised SYNC_STAGES-deep, GPIO_W-wide synchroniser with synchronous reset. It is instantiated once.
- Register file, edge detect, warm-up counter and bus logic stay in the top.

Test Plan:
- Reset then read all 8 indices: rvalid one cycle after each read; OUT=OUT_RESET, IN=0 with pins low, others 0; gpio_oe=0; irq=0.
- Write OUT=0x7, DIR=0x7FF, then SET 0x400, then CLR 0x001 -> gpio_out=0x406, gpio_oe=0x7FF; readback OUT=0x406, upper bits 0.
- gpio_in 0x000->0x001 -> IN reads 0x001 after SYNC_STAGES cycles; no irq with IRQ_EN=0. Then IRQ_EN=0x001, MODE=0, pulse bit0 -> STAT=0x001, irq=1 one cycle later; W1C 0x001 -> STAT=0, irq=0.
- IRQ_MODE=0x002, IRQ_EN=0x002, bit1 high->low -> STAT=0x002. A rising edge on bit1 does not set it.
- Same-cycle edge on bit0 and W1C 0x001 -> STAT bit0 stays 1, irq stays 1.
- Hold gpio_in=0x7FF through reset release with IRQ_EN=0x7FF -> STAT remains 0 (warm-up suppression). Assert reset during a read -> bus_rvalid=0 next cycle and all registers at reset values.
